// File: rtl/speed_plant.sv
// speed_plant: vehicle-side speed integrator closing the cruise-control loop.
// Turns brake/throttle commands into a saturating speed value on a divided tick.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   tormoz      brake command
//   pashesh     throttle level 0..7
//   load        one-cycle strobe forcing vfeli to load_speed
//   load_speed  speed value used by load
//   vfeli       current vehicle speed (registered)
//   state       mode STOP=0 ACCEL=1 COAST=2 BRAKE=3 (registered)
//   sat         last update's acceleration was clamped at MAX_SPEED
//   tick        registered pulse, high the cycle after each update
//
// Optional build macro: SPEED_PLANT_ABS_EN
//   defined   -> ramped braking, step 1 then 2 then BRAKE_STEP
//   undefined -> every brake update removes BRAKE_STEP

module speed_plant #(
    parameter int WIDTH       = 8,
    parameter int TICK_DIV    = 4,
    parameter int DRAG_PERIOD = 8,
    parameter int MAX_SPEED   = 255,
    parameter int BRAKE_STEP  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tormoz,
    input  logic [2:0]       pashesh,
    input  logic             load,
    input  logic [WIDTH-1:0] load_speed,
    output logic [WIDTH-1:0] vfeli,
    output logic [1:0]       state,
    output logic             sat,
    output logic             tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DRAG_PERIOD + 1);

    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]  DRAG_LAST = DW'(DRAG_PERIOD - 1);
    localparam logic [WIDTH:0] MAX_W1    = (WIDTH+1)'(MAX_SPEED);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_SPEED);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        ACCEL = 2'd1,
        COAST = 2'd2,
        BRAKE = 2'd3
    } mode_t;

    mode_t            mode;
    mode_t            mode_q;
    logic [TW-1:0]    tick_cnt;
    logic [DW-1:0]    drag_cnt;
    logic             upd;

    logic [WIDTH:0]   sum;
    logic             accel_clamp;
    logic [WIDTH-1:0] accel_v;
    logic [WIDTH-1:0] brake_step;
    logic [WIDTH-1:0] brake_v;
    logic             drag_hit;
    logic [WIDTH-1:0] coast_v;
    logic [WIDTH-1:0] load_v;

`ifdef SPEED_PLANT_ABS_EN
    logic [1:0]       brake_run;
`endif

    assign state = mode_q;
    assign upd   = (tick_cnt == TICK_LAST);

    // Mode priority: brake, throttle, standstill, coast.
    always_comb begin
        mode = COAST;
        if (tormoz)
            mode = BRAKE;
        else if (pashesh != 3'd0)
            mode = ACCEL;
        else if (vfeli == '0)
            mode = STOP;
    end

    // Acceleration is done one bit wider so the clamp sees true overflow.
    always_comb begin
        sum         = {1'b0, vfeli} + (WIDTH+1)'(pashesh);
        accel_clamp = (sum > MAX_W1);
        accel_v     = accel_clamp ? MAX_W : sum[WIDTH-1:0];
    end

`ifdef SPEED_PLANT_ABS_EN
    always_comb begin
        case (brake_run)
            2'd0:    brake_step = WIDTH'(1);
            2'd1:    brake_step = WIDTH'(2);
            default: brake_step = WIDTH'(BRAKE_STEP);
        endcase
    end
`else
    assign brake_step = WIDTH'(BRAKE_STEP);
`endif

    always_comb begin
        brake_v  = (vfeli > brake_step) ? (vfeli - brake_step) : '0;
        drag_hit = (drag_cnt == DRAG_LAST);
        coast_v  = (drag_hit && vfeli != '0) ? (vfeli - WIDTH'(1)) : vfeli;
        load_v   = (load_speed > MAX_W) ? MAX_W : load_speed;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vfeli     <= '0;
            mode_q    <= STOP;
            sat       <= 1'b0;
            tick      <= 1'b0;
            tick_cnt  <= '0;
            drag_cnt  <= '0;
`ifdef SPEED_PLANT_ABS_EN
            brake_run <= 2'd0;
`endif
        end else begin
            mode_q <= mode;
            tick   <= 1'b0;
            if (load) begin
                // A coincident update is dropped entirely.
                vfeli     <= load_v;
                tick_cnt  <= '0;
                drag_cnt  <= '0;
                sat       <= 1'b0;
`ifdef SPEED_PLANT_ABS_EN
                brake_run <= 2'd0;
`endif
            end else begin
                tick_cnt <= upd ? '0 : tick_cnt + TW'(1);
                if (upd) begin
                    tick <= 1'b1;
                    case (mode)
                        BRAKE: begin
                            vfeli    <= brake_v;
                            sat      <= 1'b0;
                            drag_cnt <= '0;
`ifdef SPEED_PLANT_ABS_EN
                            if (brake_run != 2'd2)
                                brake_run <= brake_run + 2'd1;
`endif
                        end
                        ACCEL: begin
                            vfeli    <= accel_v;
                            sat      <= accel_clamp;
                            drag_cnt <= '0;
`ifdef SPEED_PLANT_ABS_EN
                            brake_run <= 2'd0;
`endif
                        end
                        COAST: begin
                            vfeli    <= coast_v;
                            sat      <= 1'b0;
                            drag_cnt <= drag_hit ? '0 : drag_cnt + DW'(1);
`ifdef SPEED_PLANT_ABS_EN
                            brake_run <= 2'd0;
`endif
                        end
                        STOP: begin
                            vfeli    <= vfeli;
                            sat      <= 1'b0;
                            drag_cnt <= '0;
`ifdef SPEED_PLANT_ABS_EN
                            brake_run <= 2'd0;
`endif
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_speed_plant.sv
// tb_speed_plant: directed self-checking bench for speed_plant.
// Default parameters; ABS-specific expectations follow SPEED_PLANT_ABS_EN.

module tb_speed_plant;

    logic       clock = 1'b0;
    logic       reset;
    logic       tormoz;
    logic [2:0] pashesh;
    logic       load;
    logic [7:0] load_speed;
    logic [7:0] vfeli;
    logic [1:0] state;
    logic       sat;
    logic       tick;

    int checks = 0;
    int errors = 0;

    speed_plant dut (
        .clock      (clock),
        .reset      (reset),
        .tormoz     (tormoz),
        .pashesh    (pashesh),
        .load       (load),
        .load_speed (load_speed),
        .vfeli      (vfeli),
        .state      (state),
        .sat        (sat),
        .tick       (tick)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load       = 1'b1;
        load_speed = v;
        cyc(1);
        load       = 1'b0;
    endtask

    initial begin
        int exp_v;

        reset      = 1'b1;
        tormoz     = 1'b0;
        pashesh    = 3'd0;
        load       = 1'b0;
        load_speed = 8'd0;
        cyc(2);
        chk("rst_vfeli", 32'(vfeli), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_tick", 32'(tick), 0);

        // Throttle 3: updates on edges 4, 8, 12, 16.
        reset   = 1'b0;
        pashesh = 3'd3;
        for (int k = 1; k <= 4; k++) begin
            cyc(3);
            chk("acc_pre_tick", 32'(tick), 0);
            chk("acc_pre_v", 32'(vfeli), 32'(3 * (k - 1)));
            cyc(1);
            chk("acc_v", 32'(vfeli), 32'(3 * k));
            chk("acc_tick", 32'(tick), 1);
            chk("acc_state", 32'(state), 1);
        end

        // Saturation at MAX_SPEED.
        pashesh = 3'd7;
        do_load(8'd250);
        chk("ld250_v", 32'(vfeli), 250);
        chk("ld250_tick", 32'(tick), 0);
        cyc(4);
        chk("sat1_v", 32'(vfeli), 255);
        chk("sat1_sat", 32'(sat), 1);
        cyc(4);
        chk("sat2_v", 32'(vfeli), 255);
        chk("sat2_sat", 32'(sat), 1);

        // A brake update clears sat.
        tormoz = 1'b1;
        cyc(4);
`ifdef SPEED_PLANT_ABS_EN
        chk("brk_sat_v", 32'(vfeli), 254);
`else
        chk("brk_sat_v", 32'(vfeli), 251);
`endif
        chk("brk_sat_sat", 32'(sat), 0);
        tormoz = 1'b0;

        // Exact hit of MAX_SPEED is not a clamp.
        pashesh = 3'd1;
        do_load(8'd254);
        chk("ld254_sat", 32'(sat), 0);
        cyc(4);
        chk("hit255_v", 32'(vfeli), 255);
        chk("hit255_sat", 32'(sat), 0);

        // Brake wins over throttle.
        tormoz  = 1'b1;
        pashesh = 3'd7;
        do_load(8'd10);
        for (int k = 0; k < 4; k++) begin
            cyc(4);
`ifdef SPEED_PLANT_ABS_EN
            case (k)
                0: exp_v = 9;
                1: exp_v = 7;
                2: exp_v = 3;
                default: exp_v = 0;
            endcase
`else
            case (k)
                0: exp_v = 6;
                1: exp_v = 2;
                default: exp_v = 0;
            endcase
`endif
            chk("brk_v", 32'(vfeli), 32'(exp_v));
            chk("brk_state", 32'(state), 3);
            chk("brk_sat", 32'(sat), 0);
        end

        // Standstill with no commands.
        tormoz  = 1'b0;
        pashesh = 3'd0;
        cyc(4);
        chk("stop_v", 32'(vfeli), 0);
        chk("stop_state", 32'(state), 0);
        chk("stop_tick", 32'(tick), 1);

        // Drag: one unit per 8 coast updates.
        do_load(8'd5);
        for (int k = 1; k <= 7; k++) cyc(4);
        chk("drag7_v", 32'(vfeli), 5);
        chk("drag7_state", 32'(state), 2);
        cyc(4);
        chk("drag8_v", 32'(vfeli), 4);

        // Throttle pulse at update 5 restarts the drag count.
        do_load(8'd5);
        for (int k = 1; k <= 4; k++) cyc(4);
        chk("pulse_pre_v", 32'(vfeli), 5);
        pashesh = 3'd1;
        cyc(4);
        chk("pulse_v", 32'(vfeli), 6);
        pashesh = 3'd0;
        for (int k = 1; k <= 7; k++) cyc(4);
        chk("pulse_hold_v", 32'(vfeli), 6);
        cyc(4);
        chk("pulse_drag_v", 32'(vfeli), 5);

        // Load on the update edge beats the update.
        cyc(3);
        pashesh = 3'd2;
        do_load(8'd40);
        chk("ldupd_v", 32'(vfeli), 40);
        chk("ldupd_tick", 32'(tick), 0);
        cyc(4);
        chk("ldupd_next_v", 32'(vfeli), 42);

        // Mid-run reset, coincident load ignored.
        pashesh = 3'd0;
        do_load(8'd100);
        cyc(2);
        reset      = 1'b1;
        load       = 1'b1;
        load_speed = 8'd77;
        cyc(1);
        reset   = 1'b0;
        load    = 1'b0;
        chk("mrst_v", 32'(vfeli), 0);
        chk("mrst_state", 32'(state), 0);
        pashesh = 3'd2;
        cyc(3);
        chk("mrst_pre_v", 32'(vfeli), 0);
        chk("mrst_pre_tick", 32'(tick), 0);
        cyc(1);
        chk("mrst_upd_v", 32'(vfeli), 2);
        chk("mrst_upd_tick", 32'(tick), 1);

`ifdef SPEED_PLANT_ABS_EN
        // Ramped braking and restart after release.
        pashesh = 3'd0;
        tormoz  = 1'b1;
        do_load(8'd20);
        for (int k = 0; k < 4; k++) begin
            cyc(4);
            case (k)
                0: exp_v = 19;
                1: exp_v = 17;
                2: exp_v = 13;
                default: exp_v = 9;
            endcase
            chk("abs_v", 32'(vfeli), 32'(exp_v));
        end
        tormoz = 1'b0;
        cyc(4);
        chk("abs_rel_v", 32'(vfeli), 9);
        tormoz = 1'b1;
        cyc(4);
        chk("abs_restart_v", 32'(vfeli), 8);
        tormoz = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/speed_plant.md
Name: speed_plant

Overview:
- Vehicle-side responder for the cruise controller: takes its brake (tormoz) and throttle (pashesh) commands and integrates them into the current vehicle speed (vfeli).
- vfeli feeds back to the controller's vfeli input, closing the loop for closed-loop simulation and for on-board demonstration.
- Speed updates happen on a divided tick. Coasting applies periodic drag; all arithmetic saturates.

Parameters:
- WIDTH, 8, width of the speed value
- TICK_DIV, 4, clock cycles per speed-update tick (≥2)
- DRAG_PERIOD, 8, consecutive COAST ticks per 1-unit drag decrement (≥1)
- MAX_SPEED, 255, upper speed clamp (≤ 2^WIDTH-1)
- BRAKE_STEP, 4, speed units removed per BRAKE tick

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- tormoz  in  1  brake command from controller
- pashesh  in  3  throttle level 0..7 from controller
- load  in  1  one-cycle strobe: force speed to load_speed
- load_speed  in  WIDTH  speed value for load
- vfeli  out  WIDTH  current vehicle speed, registered
- state  out  2  mode: STOP=0, ACCEL=1, COAST=2, BRAKE=3, registered
- sat  out  1  last tick's acceleration was clamped at MAX_SPEED
- tick  out  1  registered pulse, high in the cycle after each update

Behaviour:
- Reset (synchronous, clock edge with reset=1): vfeli=0, state=STOP, sat=0, tick=0, tick_cnt=0, drag_cnt=0. Reset overrides load and tick.
- tick_cnt counts 0..TICK_DIV-1 and wraps. An update occurs on the edge where tick_cnt==TICK_DIV-1.
  - First update is on the TICK_DIV-th edge after reset deasserts.
  - The new vfeli is visible the following cycle, together with tick=1.
- Mode evaluation, every cycle, priority order:
  - tormoz=1 → BRAKE
  - else pashesh≠0 → ACCEL
  - else vfeli==0 → STOP
  - else COAST
  - state is registered from this evaluation each edge.
- Update action uses the inputs sampled on the update edge:
  - BRAKE: vfeli = max(vfeli-BRAKE_STEP, 0). Brake always wins over throttle.
  - ACCEL: vfeli = min(vfeli+pashesh, MAX_SPEED), computed at WIDTH+1 bits. sat=1 if clamped, else 0.
  - COAST: drag_cnt++. When drag_cnt==DRAG_PERIOD-1, vfeli-=1 (floor 0) and drag_cnt=0.
  - STOP: vfeli holds at 0.
- drag_cnt clears on any non-COAST update and on load.
- sat updates only on update edges. It clears on any update that is not a clamped ACCEL.
- load=1 (no reset):
  - vfeli = min(load_speed, MAX_SPEED); tick_cnt=0; drag_cnt=0; sat=0.
  - load beats a coincident update; that update is skipped and tick stays 0.
- Inputs are level-sampled; no handshake. Commands that change between updates have no effect except via state.

Optional Feature:
- Macro: SPEED_PLANT_ABS_EN
- Defined: ramped braking.
  - A brake_run counter increments on each consecutive BRAKE update, saturating at 2.
  - Step per BRAKE update: 1, then 2, then BRAKE_STEP.
  - brake_run clears on any non-BRAKE update, on load, and on reset.
- Undefined: every BRAKE update removes BRAKE_STEP; no brake_run register is present.

Test Plan (default parameters):
- Reset, then pashesh=3, tormoz=0 for 16 cycles → vfeli 3,6,9,12 after edges 4,8,12,16; tick pulses each time; state=ACCEL.
- load 250, then pashesh=7 → first update 255 with sat=1; next update stays 255, sat=1. Then pashesh=1 with load 254 → 255, sat=0.
- load 10, then tormoz=1 and pashesh=7 → 6, 2, 0, 0 over four updates; state=BRAKE; sat=0.
- load 5, all commands 0 → vfeli=4 after 8 updates (32 cycles); state=COAST. A one-update pashesh=1 pulse at update 5 → drag_cnt restarts.
- vfeli=100 mid-run, reset high for one cycle → vfeli=0, state=STOP. Next update occurs 4 edges after deassertion. load coincident with reset is ignored.
- With SPEED_PLANT_ABS_EN defined: load 20, tormoz=1 → 19, 17, 13, 9. Release for one update then re-brake → step restarts at 1.
